// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI pixel path: packer FSM states, byte lanes, word payload.
package dsi_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned PIX_BYTES  = 3;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned PIX_W      = PIX_BYTES * BYTE_W;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned PHASE_W    = 2;
    localparam int unsigned EMPTY_W    = 2;

    typedef enum logic {
        PK_RUN   = 1'b0,
        PK_FLUSH = 1'b1
    } pk_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } pk_word_t;

    // Unused high bytes of an eop word that carries nbytes valid bytes (0 means a full word)
    function automatic logic [EMPTY_W-1:0] empty_for(input logic [PHASE_W-1:0] nbytes);
        return EMPTY_W'(3'(WORD_BYTES) - 3'(nbytes));
    endfunction

endpackage

// File: rtl/st_rgb_packer.sv
// Repacks one RGB888 pixel per beat into dense 32-bit words (4 pixels -> 3 words),
// tracking line boundaries. Optional line-length checker: ST_RGB_PACKER_LINE_CHECK_EN.
module st_rgb_packer
    import dsi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned CNT_W    = 12
) (
    input  logic               clk_sys,
    input  logic               rst_sys,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    output logic               in_ready,
    output logic [31:0]        out_data,
    output logic               out_valid,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    output logic               err_line_len,
    output logic [CNT_W-1:0]   err_cnt,
    input  logic               err_clr
);

    pk_state_t          state_q, state_d;
    logic [PIX_W-1:0]   res_q, res_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sop_pend_q, sop_pend_d;
    logic               in_line_q, in_line_d;
    pk_word_t           out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               slot_c, accept_c, frame_err_c, sop_flag_c, emit_c;
    logic [PHASE_W-1:0] ph_c;
    logic [PIX_W-1:0]   rs_c, pix_c;
    pk_word_t           word_c;
    logic               unused_bits;

    assign unused_bits = ^in_data[WORD_W-1:PIX_W];
    assign pix_c       = in_data[PIX_W-1:0];
    assign slot_c      = ~out_valid_q | out_ready;
    assign in_ready    = (state_q == PK_RUN) & slot_c;
    assign accept_c    = in_valid & in_ready;
    assign frame_err_c = accept_c & in_startofpacket & ((phase_q != '0) | in_line_q);
    // Any sop restarts packing at phase 0; a leftover residual is simply discarded
    assign ph_c        = in_startofpacket ? '0 : phase_q;
    assign rs_c        = in_startofpacket ? '0 : res_q;
    assign sop_flag_c  = in_startofpacket | sop_pend_q;

    // Word completed by the current beat, selected by the residual byte count
    always_comb begin
        word_c = '0;
        emit_c = 1'b1;
        case (ph_c)
            2'd0: begin
                word_c.data  = {BYTE_W'(0), pix_c};
                word_c.eop   = in_endofpacket;
                word_c.empty = empty_for(PHASE_W'(PIX_BYTES));
                emit_c       = in_endofpacket;
            end
            2'd3:    word_c.data = {pix_c[7:0], rs_c[23:0]};
            2'd2:    word_c.data = {pix_c[15:0], rs_c[15:0]};
            default: begin
                word_c.data = {pix_c[23:0], rs_c[7:0]};
                word_c.eop  = in_endofpacket;
            end
        endcase
        word_c.sop = sop_flag_c;
    end

    // FSM next state, residual update and output register load
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        phase_d     = phase_q;
        sop_pend_d  = sop_pend_q;
        in_line_d   = in_line_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (slot_c) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            PK_RUN: begin
                if (accept_c) begin
                    in_line_d = ~in_endofpacket & (in_startofpacket | in_line_q);
                    case (ph_c)
                        2'd0: begin
                            res_d   = in_endofpacket ? '0 : pix_c;
                            phase_d = in_endofpacket ? 2'd0 : 2'd3;
                        end
                        2'd3: begin
                            res_d   = {8'h00, pix_c[23:8]};
                            phase_d = 2'd2;
                        end
                        2'd2: begin
                            res_d   = {16'h0000, pix_c[23:16]};
                            phase_d = 2'd1;
                        end
                        default: begin
                            res_d   = '0;
                            phase_d = 2'd0;
                        end
                    endcase
                    // eop leaving 1 or 2 bytes behind a full word needs a flush slot
                    if (in_endofpacket && ph_c[1]) begin
                        state_d = PK_FLUSH;
                    end
                    if (emit_c) begin
                        out_d       = word_c;
                        out_valid_d = 1'b1;
                        sop_pend_d  = 1'b0;
                    end else begin
                        sop_pend_d  = sop_flag_c;
                    end
                end
            end
            PK_FLUSH: begin
                if (slot_c) begin
                    out_d       = '0;
                    out_d.data  = {BYTE_W'(0), res_q};
                    out_d.sop   = sop_pend_q;
                    out_d.eop   = 1'b1;
                    out_d.empty = empty_for(phase_q);
                    out_valid_d = 1'b1;
                    res_d       = '0;
                    phase_d     = '0;
                    sop_pend_d  = 1'b0;
                    state_d     = PK_RUN;
                end
            end
        endcase
    end

    // Packer state and output register
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q     <= PK_RUN;
            res_q       <= '0;
            phase_q     <= '0;
            sop_pend_q  <= 1'b0;
            in_line_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            phase_q     <= phase_d;
            sop_pend_q  <= sop_pend_d;
            in_line_q   <= in_line_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data          = out_q.data;
    assign out_startofpacket = out_q.sop;
    assign out_endofpacket   = out_q.eop;
    assign out_empty         = out_q.empty;
    assign out_valid         = out_valid_q;

`ifdef ST_RGB_PACKER_LINE_CHECK_EN
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_now_c;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_flag_q, err_flag_d, err_ev_c;

    // Line length measurement and error accounting; a clear wins, then the new error counts
    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        pix_now_c  = pix_cnt_q;
        err_ev_c   = frame_err_c;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (accept_c) begin
            if (in_startofpacket) begin
                pix_now_c = CNT_W'(1);
            end else if (pix_cnt_q != '1) begin
                pix_now_c = pix_cnt_q + CNT_W'(1);
            end
            pix_cnt_d = in_endofpacket ? '0 : pix_now_c;
            if (in_endofpacket && (pix_now_c != CNT_W'(H_ACTIVE))) begin
                err_ev_c = 1'b1;
            end
        end
        if (err_clr) begin
            err_flag_d = err_ev_c;
            err_cnt_d  = err_ev_c ? CNT_W'(1) : '0;
        end else if (err_ev_c) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Checker registers
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            pix_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign err_line_len = err_flag_q;
    assign err_cnt      = err_cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg   = err_clr ^ frame_err_c ^ (H_ACTIVE == 0);
    assign err_line_len = 1'b0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_st_rgb_packer.sv
// Self-checking bench for st_rgb_packer: directed vector table, corner sequences,
// randomized lines against a byte-stream reference model.
module tb_st_rgb_packer;
    import dsi_pkg::*;

    localparam int unsigned H_ACT = 4;
    localparam int unsigned CW    = 12;
`ifdef ST_RGB_PACKER_LINE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } word_t;

    typedef struct packed {
        logic [3:0]        n_pix;
        logic [7:0][23:0]  pix;
        logic [3:0]        n_words;
        word_t [7:0]       words;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [1:0]    out_empty;
    logic          out_ready = 1'b1;
    logic          err_line_len;
    logic [CW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    int    checks = 0;
    int    passes = 0;
    bit    rand_bp = 1'b0;
    bit    force_ready = 1'b1;
    bit    gaps = 1'b0;
    word_t got_q[$];
    word_t cur_w;
    word_t prev_w = '0;
    logic  prev_stall = 1'b0;
    vec_t  vecs[5];

    st_rgb_packer #(.H_ACTIVE(H_ACT), .CNT_W(CW)) dut (
        .clk_sys(clk), .rst_sys(rst),
        .in_data(in_data), .in_valid(in_valid),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
        .out_ready(out_ready),
        .err_line_len(err_line_len), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    assign cur_w = {out_data, out_sop, out_eop, out_empty};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    // Downstream backpressure, changed mid-cycle away from both edges
    always @(posedge clk) begin
        #2;
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : force_ready;
    end

    // Output collector and hold-rule check
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) chk("hold", 64'({out_valid, cur_w}), 64'({1'b1, prev_w}));
            if (out_valid && out_ready) got_q.push_back(cur_w);
        end
        prev_stall <= !rst && out_valid && !out_ready;
        prev_w     <= cur_w;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic word_t mkw(input logic [31:0] d, input logic s, input logic e,
                                  input logic [1:0] m);
        return {d, s, e, m};
    endfunction

    task automatic addp(input int v, input logic [23:0] p);
        vecs[v].pix[vecs[v].n_pix] = p;
        vecs[v].n_pix = vecs[v].n_pix + 4'd1;
    endtask

    task automatic addw(input int v, input word_t w);
        vecs[v].words[vecs[v].n_words] = w;
        vecs[v].n_words = vecs[v].n_words + 4'd1;
    endtask

    // Drive one beat until accepted; called and returning at posedge+1
    task automatic send_beat(input logic [23:0] p, input logic s, input logic e);
        int  waited = 0;
        bit  done = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_data  = {8'($urandom), p};
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 500) begin
                    checks++;
                    $display("FAIL accept_timeout: beat 0x%0h not accepted", p);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic cmp_words(input word_t want[$], input string name);
        word_t g;
        int    t = 0;
        while (got_q.size() < want.size() && t < 3000) begin @(posedge clk); t++; end
        chk({name, "_count"}, 64'(got_q.size() >= want.size()), 64'd1);
        foreach (want[i]) begin
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            chk($sformatf("%s_w%0d", name, i), 64'(g), 64'(want[i]));
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_extra"}, 64'(got_q.size()), 64'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    word_t       e[$];
    word_t       w;
    logic [7:0]  bq[$];
    logic [23:0] p;
    int          n, nbad, cnt;

    initial begin
        // Directed vector table: pixels per line and the words they must produce
        foreach (vecs[v]) vecs[v] = '0;
        addp(0, 24'h112233); addp(0, 24'h445566); addp(0, 24'h778899); addp(0, 24'hAABBCC);
        addw(0, mkw(32'h66112233, 1, 0, 0)); addw(0, mkw(32'h88994455, 0, 0, 0));
        addw(0, mkw(32'hAABBCC77, 0, 1, 0));
        addp(1, 24'h123456);
        addw(1, mkw(32'h00123456, 1, 1, 1));
        addp(2, 24'h112233); addp(2, 24'h445566);
        addw(2, mkw(32'h66112233, 1, 0, 0)); addw(2, mkw(32'h00004455, 0, 1, 2));
        addp(3, 24'h010203); addp(3, 24'h040506); addp(3, 24'h070809);
        addw(3, mkw(32'h06010203, 1, 0, 0)); addw(3, mkw(32'h08090405, 0, 0, 0));
        addw(3, mkw(32'h00000007, 0, 1, 3));
        addp(4, 24'h111111); addp(4, 24'h222222); addp(4, 24'h333333);
        addp(4, 24'h444444); addp(4, 24'h555555);
        addw(4, mkw(32'h22111111, 1, 0, 0)); addw(4, mkw(32'h33332222, 0, 0, 0));
        addw(4, mkw(32'h44444433, 0, 0, 0)); addw(4, mkw(32'h00555555, 0, 1, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", 64'({out_valid, cur_w}), 64'd0);
        chk("reset_err", 64'({err_line_len, err_cnt}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven lines
        for (int v = 0; v < 5; v++) begin
            e.delete();
            for (int i = 0; i < int'(vecs[v].n_pix); i++)
                send_beat(vecs[v].pix[i], i == 0, i == int'(vecs[v].n_pix) - 1);
            for (int i = 0; i < int'(vecs[v].n_words); i++) e.push_back(vecs[v].words[i]);
            cmp_words(e, $sformatf("vec%0d", v));
        end

        // FLUSH bubble: in_ready low exactly while the flush word is pending
        send_beat(24'h112233, 1, 0);
        send_beat(24'h445566, 0, 1);
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        chk("flush_first", 64'(cur_w), 64'(mkw(32'h66112233, 1, 0, 0)));
        @(posedge clk); #1;
        chk("flush_ready_back", 64'(in_ready), 64'd1);
        chk("flush_word", 64'(cur_w), 64'(mkw(32'h00004455, 0, 1, 2)));
        e.delete();
        e.push_back(mkw(32'h66112233, 1, 0, 0)); e.push_back(mkw(32'h00004455, 0, 1, 2));
        cmp_words(e, "flush");

        // Backpressure mid-line: stall 5 cycles, word held, nothing lost
        force_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send_beat(24'h112233, 1, 0);
        send_beat(24'h445566, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_word", 64'({out_valid, cur_w}), 64'({1'b1, mkw(32'h66112233, 1, 0, 0)}));
        end
        force_ready = 1'b1;
        @(posedge clk); #1;
        send_beat(24'h778899, 0, 0);
        send_beat(24'hAABBCC, 0, 1);
        e.delete();
        for (int i = 0; i < 3; i++) e.push_back(vecs[0].words[i]);
        cmp_words(e, "stall");

        // Mid-line sop: residual dropped, new line starts clean, framing error
        pulse_clr();
        send_beat(24'h112233, 1, 0);
        send_beat(24'h445566, 0, 0);
        send_beat(24'h123456, 1, 1);
        e.delete();
        e.push_back(mkw(32'h66112233, 1, 0, 0)); e.push_back(mkw(32'h00123456, 1, 1, 1));
        cmp_words(e, "midsop");
        chk("midsop_err", 64'({err_line_len, err_cnt}), 64'({CHK, CW'(CHK)}));

        // Short line sets the error, clear pulse removes it
        pulse_clr();
        chk("clr_zero", 64'({err_line_len, err_cnt}), 64'd0);
        for (int i = 0; i < 3; i++) send_beat(vecs[3].pix[i], i == 0, i == 2);
        e.delete();
        for (int i = 0; i < 3; i++) e.push_back(vecs[3].words[i]);
        cmp_words(e, "short");
        chk("short_err", 64'({err_line_len, err_cnt}), 64'({CHK, CW'(CHK)}));
        // Clear and new error in the same cycle: count restarts at one
        err_clr = 1'b1;
        send_beat(24'h123456, 1, 1);
        err_clr = 1'b0;
        e.delete();
        e.push_back(mkw(32'h00123456, 1, 1, 1));
        cmp_words(e, "clr_same");
        chk("clr_same_err", 64'({err_line_len, err_cnt}), 64'({CHK, CW'(CHK)}));
        pulse_clr();
        chk("clr_after", 64'({err_line_len, err_cnt}), 64'd0);

        // Reset mid-line, then a fresh line must match the first vector
        send_beat(24'h112233, 1, 0);
        send_beat(24'h445566, 0, 0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        got_q.delete();
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) send_beat(vecs[0].pix[i], i == 0, i == 3);
        e.delete();
        for (int i = 0; i < 3; i++) e.push_back(vecs[0].words[i]);
        cmp_words(e, "rst_mid");

        // Random lines with gaps and backpressure against the byte-stream model
        pulse_clr();
        rand_bp = 1'b1;
        gaps    = 1'b1;
        e.delete();
        nbad = 0;
        for (int l = 0; l < 30; l++) begin
            n = $urandom_range(1, 12);
            if (n != int'(H_ACT)) nbad++;
            bq.delete();
            for (int i = 0; i < n; i++) begin
                p = 24'($urandom);
                send_beat(p, i == 0, i == n - 1);
                bq.push_back(p[7:0]); bq.push_back(p[15:8]); bq.push_back(p[23:16]);
            end
            for (int k = 0; k < bq.size(); k += 4) begin
                cnt = (bq.size() - k < 4) ? bq.size() - k : 4;
                w = '0;
                for (int j = 0; j < cnt; j++) w.data[8*j +: 8] = bq[k + j];
                w.sop   = (k == 0);
                w.eop   = (k + 4 >= bq.size());
                w.empty = 2'(4 - cnt);
                e.push_back(w);
            end
        end
        cmp_words(e, "rand");
        chk("rand_err_cnt", 64'(err_cnt), CHK ? 64'(nbad) : 64'd0);
        chk("rand_err_flag", 64'(err_line_len), 64'(CHK && nbad > 0));
        rand_bp = 1'b0;
        gaps    = 1'b0;

        // Error counter saturates at all-ones
        repeat (2) begin @(posedge clk); #1; end
        pulse_clr();
        for (int i = 0; i < 4100; i++) send_beat(24'h000001, 1, 1);
        repeat (3) begin @(posedge clk); #1; end
        got_q.delete();
        chk("sat_cnt", 64'(err_cnt), CHK ? 64'({CW{1'b1}}) : 64'd0);
        chk("sat_flag", 64'(err_line_len), 64'(CHK));
        pulse_clr();
        chk("sat_clr", 64'({err_line_len, err_cnt}), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
